// File: rtl/data_ram_pkg.sv
// Shared encodings for the data RAM arbiter: access sizes, requester ids, FSM states.
package data_ram_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DBG = 1'b1;

   typedef enum logic {
      ST_ARB  = 1'b0,
      ST_LOCK = 1'b1
   } arb_state_e;

   // Size code 3 has no meaning and is always rejected as misaligned.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] adr_lo);
      logic mis;
      case (size)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = adr_lo[0];
         SZ_WORD: mis = (adr_lo != 2'b00);
         default: mis = 1'b1;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/data_ram_lane.sv
// Byte-lane steering for CPU accesses: store enables/replication and load shift/extension.
module data_ram_lane
   import data_ram_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_adr_lo,
   input  logic [31:0] st_data,
   output logic [3:0]  st_wen,
   output logic [31:0] st_wdata,
   input  logic [1:0]  ld_size,
   input  logic [1:0]  ld_adr_lo,
   input  logic        ld_unsigned,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [31:0] ld_shift;

   always_comb begin
      st_wen   = 4'b0000;
      st_wdata = st_data;
      case (st_size)
         SZ_BYTE: begin
            st_wen   = 4'b0001 << st_adr_lo;
            st_wdata = {4{st_data[7:0]}};
         end
         SZ_HALF: begin
            st_wen   = st_adr_lo[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{st_data[15:0]}};
         end
         SZ_WORD: st_wen = 4'b1111;
         default: st_wen = 4'b0000;
      endcase
   end

   always_comb begin
      ld_shift = ld_word;
      ld_data  = ld_shift;
      case (ld_size)
         SZ_BYTE: begin
            ld_shift = ld_word >> {ld_adr_lo, 3'b000};
            ld_data  = {{24{~ld_unsigned & ld_shift[7]}}, ld_shift[7:0]};
         end
         SZ_HALF: begin
            ld_shift = ld_word >> {ld_adr_lo[1], 4'b0000};
            ld_data  = {{16{~ld_unsigned & ld_shift[15]}}, ld_shift[15:0]};
         end
         default: ld_data = ld_shift;
      endcase
   end

endmodule

// File: rtl/data_ram_arb.sv
// Arbitrates the CPU MA stage and the debug monitor onto one 1R1W data RAM.
// Define DATA_RAM_ARB_STARVE_EN to let a debug requester that keeps losing win a conflict.
//
// state   | meaning
// ST_ARB  | normal arbitration, CPU has priority
// ST_LOCK | debug holds the RAM exclusively, CPU stalled
module data_ram_arb
   import data_ram_pkg::*;
#(
   parameter int DRWIDTH    = 9,
   parameter int STARVE_MAX = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cpu_req,
   input  logic               cpu_we,
   input  logic [DRWIDTH+1:0] cpu_adr,
   input  logic [1:0]         cpu_size,
   input  logic               cpu_unsigned,
   input  logic [31:0]        cpu_wdata,
   output logic               cpu_gnt,
   output logic               cpu_misalign,
   output logic               cpu_rvalid,
   output logic [31:0]        cpu_rdata,
   input  logic               dbg_req,
   input  logic               dbg_we,
   input  logic               dbg_lock,
   input  logic [DRWIDTH-1:0] dbg_adr,
   input  logic [31:0]        dbg_wdata,
   output logic               dbg_gnt,
   output logic               dbg_rvalid,
   output logic [31:0]        dbg_rdata,
   output logic               dbg_locked,
   output logic [DRWIDTH-1:0] ram_radr,
   input  logic [31:0]        ram_rdata,
   output logic [DRWIDTH-1:0] ram_wadr,
   output logic [31:0]        ram_wdata,
   output logic [3:0]         ram_wen
);

   if (DRWIDTH < 1 || STARVE_MAX < 1) begin : g_param_chk
      $error("data_ram_arb: DRWIDTH and STARVE_MAX must be at least 1");
   end

   arb_state_e state_q, state_d;
   logic       cpu_rd_q, cpu_rd_d;
   logic       dbg_rd_q, dbg_rd_d;
   logic [1:0] ld_size_q, ld_size_d;
   logic [1:0] ld_adr_lo_q, ld_adr_lo_d;
   logic       ld_uns_q, ld_uns_d;

   logic               cpu_mis;
   logic               cpu_acc;
   logic               dbg_wins;
   logic               owner;
   logic [DRWIDTH-1:0] ram_adr;
   logic [3:0]         st_wen;
   logic [31:0]        st_wdata;
   logic [31:0]        ld_data;

   assign cpu_mis = is_misaligned(cpu_size, cpu_adr[1:0]);

`ifdef DATA_RAM_ARB_STARVE_EN
   localparam int SCW = $clog2(STARVE_MAX + 1);

   // Down-counts the conflicts debug may still lose; zero means debug takes the next one.
   logic [SCW-1:0] starve_left_q, starve_left_d;

   assign dbg_wins = (starve_left_q == '0);

   always_comb begin
      starve_left_d = starve_left_q;
      if (dbg_gnt || !dbg_req) begin
         starve_left_d = SCW'(STARVE_MAX);
      end else if (state_q == ST_ARB && starve_left_q != '0) begin
         starve_left_d = starve_left_q - SCW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_left_q <= SCW'(STARVE_MAX);
      end else begin
         starve_left_q <= starve_left_d;
      end
   end
`else
   assign dbg_wins = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
      if (!rst) begin
         case (state_q)
            ST_ARB: begin
               cpu_gnt = cpu_req & ~(dbg_req & dbg_wins);
               dbg_gnt = dbg_req & ~cpu_gnt;
               if (dbg_lock && !cpu_gnt) state_d = ST_LOCK;
            end
            ST_LOCK: begin
               dbg_gnt = dbg_req;
               if (!dbg_lock) state_d = ST_ARB;
            end
            default: state_d = ST_ARB;
         endcase
      end
   end

   data_ram_lane u_lane (
      .st_size     (cpu_size),
      .st_adr_lo   (cpu_adr[1:0]),
      .st_data     (cpu_wdata),
      .st_wen      (st_wen),
      .st_wdata    (st_wdata),
      .ld_size     (ld_size_q),
      .ld_adr_lo   (ld_adr_lo_q),
      .ld_unsigned (ld_uns_q),
      .ld_word     (ram_rdata),
      .ld_data     (ld_data)
   );

   // A misaligned CPU access is acknowledged but never reaches the RAM.
   always_comb begin
      cpu_acc      = cpu_gnt & ~cpu_mis;
      cpu_misalign = cpu_gnt & cpu_mis;
      owner        = dbg_gnt ? REQ_DBG : REQ_CPU;
      ram_adr      = (owner == REQ_DBG) ? dbg_adr : cpu_adr[DRWIDTH+1:2];
      ram_radr     = ram_adr;
      ram_wadr     = ram_adr;
      ram_wdata    = (owner == REQ_DBG) ? dbg_wdata : st_wdata;
      ram_wen      = 4'b0000;
      if (cpu_acc && cpu_we) begin
         ram_wen = st_wen;
      end else if (dbg_gnt && dbg_we) begin
         ram_wen = 4'b1111;
      end
   end

   always_comb begin
      cpu_rd_d    = cpu_acc & ~cpu_we;
      dbg_rd_d    = dbg_gnt & ~dbg_we;
      ld_size_d   = cpu_rd_d ? cpu_size     : ld_size_q;
      ld_adr_lo_d = cpu_rd_d ? cpu_adr[1:0] : ld_adr_lo_q;
      ld_uns_d    = cpu_rd_d ? cpu_unsigned : ld_uns_q;
   end

   always_comb begin
      cpu_rvalid = cpu_rd_q & ~rst;
      dbg_rvalid = dbg_rd_q & ~rst;
      cpu_rdata  = cpu_rvalid ? ld_data : 32'h0;
      dbg_rdata  = dbg_rvalid ? ram_rdata : 32'h0;
      dbg_locked = (state_q == ST_LOCK) & ~rst;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_ARB;
         cpu_rd_q    <= 1'b0;
         dbg_rd_q    <= 1'b0;
         ld_size_q   <= SZ_BYTE;
         ld_adr_lo_q <= 2'b00;
         ld_uns_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cpu_rd_q    <= cpu_rd_d;
         dbg_rd_q    <= dbg_rd_d;
         ld_size_q   <= ld_size_d;
         ld_adr_lo_q <= ld_adr_lo_d;
         ld_uns_q    <= ld_uns_d;
      end
   end

endmodule

// File: doc/data_ram_arb.md
DATA_RAM_ARB -- requirements
Module: data_ram_arb

Interface
REQ-001 Parameter DRWIDTH, default 9, word-address width of the attached data_1r1w-style RAM.
REQ-002 Parameter STARVE_MAX, default 8, consecutive waiting cycles before the debug requester is forced a grant.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 cpu_req / cpu_we  in  1/1  MA-stage access request; write when cpu_we=1.
REQ-006 cpu_adr  in  DRWIDTH+2  byte address; cpu_size in 2 (0=byte, 1=half, 2=word); cpu_unsigned in 1 (load zero-extend).
REQ-007 cpu_wdata  in  32  store data, right-aligned (LSBs).
REQ-008 cpu_gnt  out  1  access accepted this cycle; cpu_misalign out 1 misaligned pulse.
REQ-009 cpu_rvalid  out  1  load data valid; cpu_rdata out 32 aligned and extended load data.
REQ-010 dbg_req / dbg_we / dbg_lock  in  1/1/1  debug-monitor request, write select, exclusive-lock request.
REQ-011 dbg_adr  in  DRWIDTH  word address; dbg_wdata in 32 full-word write data.
REQ-012 dbg_gnt / dbg_rvalid  out  1/1; dbg_rdata out 32 raw word; dbg_locked out 1 lock held.
REQ-013 ram_radr out DRWIDTH; ram_rdata in 32 (valid one cycle after ram_radr); ram_wadr out DRWIDTH; ram_wdata out 32; ram_wen out 4.

Function
REQ-014 At most one requester SHALL be granted per cycle; a grant is combinational from the current req and registered state.
REQ-015 Default priority SHALL be CPU over debug.
REQ-016 Granted read: ram_radr=word address in cycle N; matching rvalid=1 with data in cycle N+1 only; the other rvalid stays 0.
REQ-017 Granted write: ram_wadr, ram_wdata, ram_wen driven in cycle N; no rvalid.
REQ-018 CPU store lanes: byte -> wen=1<<adr[1:0], wdata=byte replicated x4; half -> wen=4'b0011 or 4'b1100 by adr[1], half replicated x2; word -> 4'b1111.
REQ-019 CPU load: word shifted right by 8*adr[1:0] (byte) or 16*adr[1] (half), then sign- or zero-extended per registered cpu_unsigned.
REQ-020 Misaligned CPU access (half with adr[0]=1, word with adr[1:0]!=0, size=3): cpu_misalign=1 and cpu_gnt=1 that cycle, ram_wen=0, no rvalid, RAM untouched.
REQ-021 Debug writes SHALL use wen=4'b1111.
REQ-022 ram_wen SHALL be 0 in every cycle without a granted write.
REQ-023 FSM states ARB and LOCK; ARB->LOCK when dbg_lock=1 at a cycle with no CPU grant; LOCK->ARB when dbg_lock=0.
REQ-024 In LOCK, cpu_gnt=0 and debug is granted whenever dbg_req=1; dbg_locked=1 exactly while in LOCK.
REQ-025 dbg_lock deasserted during LOCK while a debug read is outstanding: the read SHALL still complete with dbg_rvalid next cycle.
REQ-026 Simultaneous cpu_req and dbg_req in ARB: CPU wins unless the starvation rule (REQ-030) applies.

Reset
REQ-027 While rst=1: FSM=ARB, starvation counter=0, all gnt/rvalid/misalign/locked outputs 0, ram_wen=0, pending-read registers cleared.
REQ-028 rst asserted with a read outstanding: the read SHALL be discarded; no rvalid in the cycle after rst deasserts.

Configuration
REQ-029 Macro DATA_RAM_ARB_STARVE_EN selects starvation protection.
REQ-030 Defined: counter increments each ARB cycle with dbg_req=1 and dbg_gnt=0, saturating at STARVE_MAX; at STARVE_MAX debug wins over CPU next conflict; cleared on dbg_gnt or dbg_req=0.
REQ-031 Undefined: no counter; strict CPU priority in ARB; debug may starve.

Structure
REQ-032 Shared package data_ram_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, requester-id constants.
REQ-033 One sub-module data_ram_lane: combinational lane-enable/replicate for stores and shift/extend for loads.

Verification
REQ-034 CPU sb 0xA5 to byte adr 0x006 -> ram_wadr=1, ram_wen=4'b0100, ram_wdata=0xA5A5A5A5.
REQ-035 RAM word 1 = 0x80FF1234; CPU lh adr 0x006 signed -> next cycle cpu_rvalid=1, cpu_rdata=0xFFFF80FF; lhu -> 0x000080FF.
REQ-036 CPU lw adr 0x002 -> cpu_misalign=1 one cycle, ram_wen=0, no cpu_rvalid.
REQ-037 STARVE_EN defined, cpu_req and dbg_req held high 20 cycles -> dbg_gnt first asserted in cycle 9 (after 8 losses), counter back to 0.
REQ-038 dbg_lock=1 with cpu_req=1 held -> after entering LOCK, cpu_gnt=0 while debug writes 0x12345678 to word 3 with wen=4'b1111; dbg_lock=0 -> CPU granted next cycle.
REQ-039 rst pulsed the cycle after a debug read grant -> dbg_rvalid stays 0 and all outputs at reset values.
